// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and limits for countdown_timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam int DEFAULT_TICKS_PER_SEC = 60;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD digit that counts down, wraps to MAX and borrows
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Load saturates to MAX; a decrement from 0 wraps to MAX and borrows upward
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val > MAX) ? MAX : load_val;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
    end
  end

  // Digit register
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec && !load && (q_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - M:SS countdown timer driven by a frame-rate tick
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] load_min,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  output logic [3:0] min_digit,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [5:0] frame_cnt,
  output logic [1:0] state,
  output logic       running,
  output logic       sec_pulse,
  output logic       done
);

  localparam logic [5:0] FRAME_LAST = 6'(TICKS_PER_SEC - 1);

  state_e     state_q, state_d;
  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic       running_q, running_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       done_q, done_d;

  logic       is_zero;
  logic       last_sec;
  logic       tick_en;
  logic       sec_dec;
  logic       ones_borrow;
  logic       tens_borrow;
  logic       unused_min_borrow;

  assign is_zero  = (min_digit == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign last_sec = (min_digit == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // load and pause both outrank tick, so either one swallows a same-cycle tick
  assign tick_en = (state_q == RUNNING) && !load && !pause && tick;
  assign sec_dec = tick_en && (frame_cnt_q == FRAME_LAST) && !is_zero;

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_ones (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_val   (load_sec_ones),
    .dec        (sec_dec),
    .q          (sec_ones),
    .borrow_out (ones_borrow)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_val   (load_sec_tens),
    .dec        (ones_borrow),
    .q          (sec_tens),
    .borrow_out (tens_borrow)
  );

  // Minutes never borrow: zero detection stops counting at 0:00
  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_val   (load_min),
    .dec        (tens_borrow),
    .q          (min_digit),
    .borrow_out (unused_min_borrow)
  );

  // State, frame counter and pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= 6'd0;
      running_q   <= 1'b0;
      sec_pulse_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      running_q   <= running_d;
      sec_pulse_q <= sec_pulse_d;
      done_q      <= done_d;
    end
  end

  // Next-state: load returns to IDLE from anywhere; pause outranks start
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && !pause && !is_zero) state_d = RUNNING;
        RUNNING: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (sec_dec && last_sec) begin
            state_d = EXPIRED;
          end
        end
        PAUSED:  if (start && !pause) state_d = RUNNING;
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: frame counter advance/wrap, registered running flag and pulses
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (load) begin
      frame_cnt_d = 6'd0;
    end else if (tick_en) begin
      frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? 6'd0 : frame_cnt_q + 6'd1;
    end
    running_d   = (state_d == RUNNING);
    sec_pulse_d = sec_dec;
    done_d      = sec_dec && last_sec;
  end

  assign frame_cnt = frame_cnt_q;
  assign state     = state_q;
  assign running   = running_q;
  assign sec_pulse = sec_pulse_q;
  assign done      = done_q;

endmodule
